// File: rtl/timer_pkg.sv
// Shared mode encodings, BCD digit type and the 7-segment glyph table for the timer core.
package timer_pkg;

    localparam logic [1:0] MODE_CLOCK     = 2'b00;
    localparam logic [1:0] MODE_STOPWATCH = 2'b01;
    localparam logic [1:0] MODE_COUNTDOWN = 2'b10;
    localparam logic [1:0] MODE_HOLD      = 2'b11;

    typedef logic [3:0] bcd_t;

    // Active-high glyphs {g..a}; codes above 9 render blank.
    function automatic logic [6:0] seg7_pattern(input bcd_t d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'b0111111;
            4'd1:    p = 7'b0000110;
            4'd2:    p = 7'b1011011;
            4'd3:    p = 7'b1001111;
            4'd4:    p = 7'b1100110;
            4'd5:    p = 7'b1101101;
            4'd6:    p = 7'b1111101;
            4'd7:    p = 7'b0000111;
            4'd8:    p = 7'b1111111;
            4'd9:    p = 7'b1101111;
            default: p = 7'b0000000;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/bcd_seg7_enc.sv
// Combinational BCD digit to 7-segment encoder with selectable segment polarity.
module bcd_seg7_enc
    import timer_pkg::*;
#(
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = (SEG_ACTIVE_LOW != 0) ? ~seg7_pattern(bcd) : seg7_pattern(bcd);
    end

endmodule

// File: rtl/timer_multimode.sv
// Multi-mode BCD time base (clock / stopwatch / countdown) with load handshake and
// registered six-digit 7-segment outputs.
module timer_multimode
    import timer_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ     = 50_000_000,
    parameter int unsigned HOUR24         = 1,
    parameter int unsigned SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  i_mode,
    input  logic        i_run,
    input  logic        i_load_valid,
    input  logic [23:0] i_load_bcd,
    output logic        o_load_ready,
    output logic        o_load_err,
    output logic        o_tick,
    output logic        o_expired,
    output logic        o_pm,
    output logic [6:0]  o_HEX0,
    output logic [6:0]  o_HEX1,
    output logic [6:0]  o_HEX2,
    output logic [6:0]  o_HEX3,
    output logic [6:0]  o_HEX4,
    output logic [6:0]  o_HEX5
);

    localparam int unsigned PW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLOCK_FREQ - 1);
    localparam logic [6:0] SEG_ZERO =
        (SEG_ACTIVE_LOW != 0) ? ~seg7_pattern(4'd0) : seg7_pattern(4'd0);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick_q, tick_d;
    logic          err_q, expired_q, expired_d, pm_q, pm_d;
    logic [1:0]    mode_q;
    logic [23:0]   time_q, time_d, time_inc, time_dec;
    logic          load_hs, load_bad, load_ok, mode_chg, advance;
    bcd_t          ss_u, ss_t, mm_u, mm_t, hh_u, hh_t;

    assign {hh_t, hh_u, mm_t, mm_u, ss_t, ss_u} = time_q;

    assign o_load_ready = ~rst & ~tick_q;
    assign load_hs      = i_load_valid & o_load_ready;
    assign load_ok      = load_hs & ~load_bad;
    assign mode_chg     = (i_mode != mode_q);
    assign advance      = i_run & (i_mode != MODE_HOLD);

    always_comb begin
        load_bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i_load_bcd[4*i +: 4] > 4'd9) load_bad = 1'b1;
        end
        if (i_load_bcd[7:4] > 4'd5 || i_load_bcd[15:12] > 4'd5) load_bad = 1'b1;
        // BCD ordering matches hex ordering once every nibble is a valid digit.
        if (i_mode == MODE_CLOCK && i_load_bcd[23:16] > 8'h23) load_bad = 1'b1;
    end

    // Incrementing carry chain.
    logic c_su, c_st, c_mu, c_mt, hh_wrap;
    always_comb begin
        c_su    = (ss_u == 4'd9);
        c_st    = c_su && (ss_t == 4'd5);
        c_mu    = c_st && (mm_u == 4'd9);
        c_mt    = c_mu && (mm_t == 4'd5);
        hh_wrap = (i_mode == MODE_CLOCK) ? ({hh_t, hh_u} == 8'h23) : ({hh_t, hh_u} == 8'h99);
        time_inc       = time_q;
        time_inc[3:0]  = c_su ? 4'd0 : ss_u + 4'd1;
        if (c_su) time_inc[7:4]   = c_st ? 4'd0 : ss_t + 4'd1;
        if (c_st) time_inc[11:8]  = c_mu ? 4'd0 : mm_u + 4'd1;
        if (c_mu) time_inc[15:12] = c_mt ? 4'd0 : mm_t + 4'd1;
        if (c_mt) begin
            if (hh_wrap)           time_inc[23:16] = 8'h00;
            else if (hh_u == 4'd9) time_inc[23:16] = {hh_t + 4'd1, 4'd0};
            else                   time_inc[19:16] = hh_u + 4'd1;
        end
    end

    // Decrementing borrow chain; never applied to 00:00:00.
    logic b_su, b_st, b_mu, b_mt, b_hu;
    always_comb begin
        b_su = (ss_u == 4'd0);
        b_st = b_su && (ss_t == 4'd0);
        b_mu = b_st && (mm_u == 4'd0);
        b_mt = b_mu && (mm_t == 4'd0);
        b_hu = b_mt && (hh_u == 4'd0);
        time_dec      = time_q;
        time_dec[3:0] = b_su ? 4'd9 : ss_u - 4'd1;
        if (b_su) time_dec[7:4]   = b_st ? 4'd5 : ss_t - 4'd1;
        if (b_st) time_dec[11:8]  = b_mu ? 4'd9 : mm_u - 4'd1;
        if (b_mu) time_dec[15:12] = b_mt ? 4'd5 : mm_t - 4'd1;
        if (b_mt) time_dec[19:16] = b_hu ? 4'd9 : hh_u - 4'd1;
        if (b_hu) time_dec[23:20] = hh_t - 4'd1;
    end

    always_comb begin
        presc_d   = presc_q;
        tick_d    = 1'b0;
        time_d    = time_q;
        expired_d = expired_q;
        if (load_ok || mode_chg) begin
            presc_d = '0;
        end else if (advance) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                tick_d  = 1'b1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
        if (load_ok) begin
            time_d    = i_load_bcd;
            expired_d = 1'b0;
        end else if (mode_chg) begin
            expired_d = 1'b0;
        end else if (tick_q) begin
            case (i_mode)
                MODE_CLOCK, MODE_STOPWATCH: time_d = time_inc;
                MODE_COUNTDOWN: begin
                    if (time_q == 24'h0) begin
                        expired_d = 1'b1;
                    end else begin
                        time_d = time_dec;
                        if (time_dec == 24'h0) expired_d = 1'b1;
                    end
                end
                default: time_d = time_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q   <= '0;
            tick_q    <= 1'b0;
            err_q     <= 1'b0;
            expired_q <= 1'b0;
            time_q    <= 24'h0;
            mode_q    <= i_mode;
        end else begin
            presc_q   <= presc_d;
            tick_q    <= tick_d;
            err_q     <= load_hs & load_bad;
            expired_q <= expired_d;
            time_q    <= time_d;
            mode_q    <= i_mode;
        end
    end

    // Display digits, with 12 h hour folding in clock mode.
    logic       twelve;
    logic [7:0] hh_bin, hh_12;
    bcd_t       digit [6];
    always_comb begin
        twelve = (HOUR24 == 0) && (i_mode == MODE_CLOCK);
        hh_bin = 8'(hh_t) * 8'd10 + 8'(hh_u);
        if (hh_bin == 8'd0)       hh_12 = 8'd12;
        else if (hh_bin > 8'd12)  hh_12 = hh_bin - 8'd12;
        else                      hh_12 = hh_bin;
        pm_d     = twelve && (hh_bin >= 8'd12);
        digit[0] = ss_u;
        digit[1] = ss_t;
        digit[2] = mm_u;
        digit[3] = mm_t;
        if (twelve) begin
            digit[5] = (hh_12 >= 8'd10) ? 4'd1 : 4'd0;
            digit[4] = (hh_12 >= 8'd10) ? 4'(hh_12 - 8'd10) : hh_12[3:0];
        end else begin
            digit[5] = hh_t;
            digit[4] = hh_u;
        end
    end

    logic [6:0] seg   [6];
    logic [6:0] hex_q [6];

    for (genvar g = 0; g < 6; g++) begin : g_enc
        bcd_seg7_enc #(
            .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
        ) u_enc (
            .bcd(digit[g]),
            .seg(seg[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 6; i++) hex_q[i] <= SEG_ZERO;
            pm_q <= 1'b0;
        end else begin
            for (int i = 0; i < 6; i++) hex_q[i] <= seg[i];
            pm_q <= pm_d;
        end
    end

    assign o_tick     = tick_q;
    assign o_load_err = err_q;
    assign o_expired  = expired_q;
    assign o_pm       = pm_q;
    assign o_HEX0     = hex_q[0];
    assign o_HEX1     = hex_q[1];
    assign o_HEX2     = hex_q[2];
    assign o_HEX3     = hex_q[3];
    assign o_HEX4     = hex_q[4];
    assign o_HEX5     = hex_q[5];

endmodule

// File: tb/tb_timer_multimode.sv
// Directed bench for timer_multimode: table of load/tick vectors plus hand-written corner sequences.
module tb_timer_multimode;

    logic        clk;
    logic        rst;
    logic [1:0]  i_mode;
    logic        i_run;
    logic        i_load_valid;
    logic [23:0] i_load_bcd;
    logic        o_load_ready, o_load_err, o_tick, o_expired, o_pm;
    logic [6:0]  o_HEX0, o_HEX1, o_HEX2, o_HEX3, o_HEX4, o_HEX5;

    int n_cmp = 0;
    int n_err = 0;

    timer_multimode #(
        .CLOCK_FREQ(4),
        .HOUR24(0),
        .SEG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .i_mode(i_mode),
        .i_run(i_run),
        .i_load_valid(i_load_valid),
        .i_load_bcd(i_load_bcd),
        .o_load_ready(o_load_ready),
        .o_load_err(o_load_err),
        .o_tick(o_tick),
        .o_expired(o_expired),
        .o_pm(o_pm),
        .o_HEX0(o_HEX0),
        .o_HEX1(o_HEX1),
        .o_HEX2(o_HEX2),
        .o_HEX3(o_HEX3),
        .o_HEX4(o_HEX4),
        .o_HEX5(o_HEX5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  mode;
        logic        do_load;
        logic [23:0] load;
        int          ticks;
        logic        exp_err;
        logic [23:0] exp_disp;
        logic        exp_pm;
        logic        exp_expired;
    } vec_t;

    function automatic logic [6:0] seg_al(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [41:0] exp_hex(input logic [23:0] d);
        logic [41:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) r[7*i +: 7] = seg_al(d[4*i +: 4]);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_disp(input string name, input logic [23:0] d);
        check(name, 64'({o_HEX5, o_HEX4, o_HEX3, o_HEX2, o_HEX1, o_HEX0}), 64'(exp_hex(d)));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input string name, input int n);
        int cnt = 0;
        for (int k = 0; k < 40 * n && cnt < n; k++) begin
            step();
            if (o_tick) cnt++;
        end
        check(name, 64'(cnt), 64'(n));
    endtask

    task automatic do_load(input string name, input logic [23:0] v);
        int k = 0;
        i_load_bcd   = v;
        i_load_valid = 1'b1;
        while (!o_load_ready && k < 20) begin
            step();
            k++;
        end
        check(name, 64'(o_load_ready), 64'(1));
        step();
        i_load_valid = 1'b0;
    endtask

    vec_t vecs [13];

    initial begin
        int cyc;
        int cnt;

        vecs[0]  = '{2'b00, 1'b1, 24'h235958, 0, 1'b0, 24'h115958, 1'b1, 1'b0};
        vecs[1]  = '{2'b00, 1'b0, 24'h000000, 2, 1'b0, 24'h120000, 1'b0, 1'b0};
        vecs[2]  = '{2'b10, 1'b1, 24'h000002, 1, 1'b0, 24'h000001, 1'b0, 1'b0};
        vecs[3]  = '{2'b10, 1'b0, 24'h000000, 1, 1'b0, 24'h000000, 1'b0, 1'b1};
        vecs[4]  = '{2'b10, 1'b0, 24'h000000, 1, 1'b0, 24'h000000, 1'b0, 1'b1};
        vecs[5]  = '{2'b10, 1'b1, 24'h000010, 1, 1'b0, 24'h000009, 1'b0, 1'b0};
        vecs[6]  = '{2'b00, 1'b1, 24'h240000, 0, 1'b1, 24'h120009, 1'b0, 1'b0};
        vecs[7]  = '{2'b01, 1'b1, 24'h240000, 0, 1'b0, 24'h240000, 1'b0, 1'b0};
        vecs[8]  = '{2'b00, 1'b1, 24'h125959, 1, 1'b0, 24'h010000, 1'b1, 1'b0};
        vecs[9]  = '{2'b00, 1'b1, 24'h005A00, 0, 1'b1, 24'h010000, 1'b1, 1'b0};
        vecs[10] = '{2'b00, 1'b1, 24'h006000, 0, 1'b1, 24'h010000, 1'b1, 1'b0};
        vecs[11] = '{2'b10, 1'b1, 24'h010000, 1, 1'b0, 24'h005959, 1'b0, 1'b0};
        vecs[12] = '{2'b01, 1'b1, 24'h995959, 1, 1'b0, 24'h000000, 1'b0, 1'b0};

        rst = 1'b1;
        i_mode = 2'b00;
        i_run = 1'b1;
        i_load_valid = 1'b0;
        i_load_bcd = 24'h0;

        // Reset state
        step();
        check_disp("rst_hex", 24'h000000);
        check("rst_ready", 64'(o_load_ready), 64'(0));
        step();
        step();
        check("rst_tick", 64'(o_tick), 64'(0));
        check("rst_expired", 64'(o_expired), 64'(0));
        check("rst_pm", 64'(o_pm), 64'(0));
        rst = 1'b0;
        #1;
        check("ready_after_rst", 64'(o_load_ready), 64'(1));

        // Tick period and 60 ticks in clock mode
        wait_ticks("first_tick", 1);
        cyc = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            cyc++;
            if (o_tick) break;
        end
        check("tick_period", 64'(cyc), 64'(4));
        wait_ticks("ticks_58", 58);
        step();
        step();
        check("min_sec_60", 64'({o_HEX3, o_HEX2, o_HEX1, o_HEX0}),
              64'(exp_hex(24'h000100) & 42'h0FFFFFFF));
        check_disp("disp_60", 24'h120100);

        // Table-driven load/tick vectors
        for (int i = 0; i < 13; i++) begin
            i_run = 1'b0;
            i_mode = vecs[i].mode;
            step();
            if (vecs[i].do_load) begin
                do_load($sformatf("v%0d_ready", i), vecs[i].load);
                check($sformatf("v%0d_err", i), 64'(o_load_err), 64'(vecs[i].exp_err));
                step();
                check($sformatf("v%0d_err_pulse", i), 64'(o_load_err), 64'(0));
            end else begin
                step();
            end
            if (vecs[i].ticks > 0) begin
                i_run = 1'b1;
                wait_ticks($sformatf("v%0d_ticks", i), vecs[i].ticks);
                step();
                step();
                i_run = 1'b0;
            end
            check_disp($sformatf("v%0d_disp", i), vecs[i].exp_disp);
            check($sformatf("v%0d_pm", i), 64'(o_pm), 64'(vecs[i].exp_pm));
            check($sformatf("v%0d_expired", i), 64'(o_expired), 64'(vecs[i].exp_expired));
        end

        // Countdown entered at 00:00:00 expires on the next tick, not on entry
        i_mode = 2'b10;
        i_run = 1'b1;
        step();
        step();
        check("cd_entry_expired", 64'(o_expired), 64'(0));
        wait_ticks("cd_entry_tick", 1);
        step();
        step();
        check("cd_entry_expired_tick", 64'(o_expired), 64'(1));
        check_disp("cd_entry_disp", 24'h000000);

        // Load presented in the tick cycle
        i_mode = 2'b00;
        step();
        check("cd_mode_clear", 64'(o_expired), 64'(0));
        cnt = 0;
        for (int k = 0; k < 20 && !o_tick; k++) step();
        check("tick_seen", 64'(o_tick), 64'(1));
        i_load_bcd = 24'h101010;
        i_load_valid = 1'b1;
        check("ready_on_tick", 64'(o_load_ready), 64'(0));
        step();
        check("ready_after_tick", 64'(o_load_ready), 64'(1));
        step();
        i_load_valid = 1'b0;
        step();
        check_disp("load_on_tick_disp", 24'h101010);
        check("load_on_tick_pm", 64'(o_pm), 64'(0));

        // Hold mode: no ticks, time frozen
        i_mode = 2'b11;
        for (int k = 0; k < 20; k++) begin
            step();
            if (o_tick) cnt++;
        end
        check("hold_ticks", 64'(cnt), 64'(0));
        check_disp("hold_disp", 24'h101010);

        // Reset mid-count overrides a simultaneous load
        i_mode = 2'b00;
        step();
        step();
        rst = 1'b1;
        i_load_bcd = 24'h235959;
        i_load_valid = 1'b1;
        step();
        check_disp("midrst_hex", 24'h000000);
        check("midrst_ready", 64'(o_load_ready), 64'(0));
        check("midrst_pm", 64'(o_pm), 64'(0));
        rst = 1'b0;
        i_load_valid = 1'b0;
        step();
        step();
        check_disp("post_rst_disp", 24'h120000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
